// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point datapath.
// Widths are supplied by the instantiating module; the helpers derive its constants.
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    // Default-width {s, e, m} layout; modules declare the same shape locally from E_W/M_W.
    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
    } fp_bf16_t;

    function automatic longint unsigned fp_bias(input int unsigned e_w);
        return (64'(1) << (e_w - 1)) - 64'(1);
    endfunction

    function automatic longint unsigned fp_all_ones(input int unsigned w);
        return (64'(1) << w) - 64'(1);
    endfunction

    function automatic longint unsigned fp_qnan_mant(input int unsigned m_w);
        return 64'(1) << (m_w - 1);
    endfunction

    // Subnormals are classed as ZERO (flush-to-zero on input).
    function automatic fp_class_e fp_classify(input logic e_zero, input logic e_ones,
                                              input logic m_nz);
        if (e_zero)
            return ZERO;
        else if (e_ones)
            return m_nz ? NAN : INF;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input yields W.
module fp_lzc #(
    parameter int unsigned W  = 12,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        cnt = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (din[i])
                cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder (align, add, normalise/round), FTZ.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int unsigned E_W = 8,
    parameter int unsigned M_W = 7
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic           sa_i,
    input  logic [E_W-1:0] ea_i,
    input  logic [M_W-1:0] ma_i,
    input  logic           sb_i,
    input  logic [E_W-1:0] eb_i,
    input  logic [M_W-1:0] mb_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic           s_o,
    output logic [E_W-1:0] e_o,
    output logic [M_W-1:0] m_o,
    output logic [2:0]     flags_o
);

    localparam int unsigned MW4 = M_W + 4;
    localparam int unsigned SW  = M_W + 5;
    localparam int unsigned LW  = $clog2(SW + 1);
    localparam logic [E_W-1:0] E_ONES = E_W'(fp_all_ones(E_W));
    localparam logic [M_W-1:0] QNAN_M = M_W'(fp_qnan_mant(M_W));
    localparam logic [E_W-1:0] FAR    = E_W'(M_W + 3);

    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [M_W-1:0] m;
    } fp_t;

    typedef struct packed {
        logic           s_big;
        logic           sub;
        logic [E_W-1:0] e_big;
        logic [MW4-1:0] mag_big;
        logic [MW4-1:0] mag_sm;
        logic           nan;
        logic           inf;
        logic           inf_s;
        logic           zsign;
    } s1_t;

    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [SW-1:0]  sum;
        logic           nan;
        logic           inf;
        logic           inf_s;
        logic           zsign;
    } s2_t;

    logic init_done, v1, v2, v3;
    logic adv1, adv2, adv3;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    // Handshake: ready_o is additionally held low until the first edge after reset.
    assign adv3    = !v3 | ready_i;
    assign adv2    = !v2 | adv3;
    assign adv1    = !v1 | adv2;
    assign ready_o = init_done & adv1;
    assign valid_o = v3;

    // ---------------- Stage 1: classify, swap, align ----------------
    fp_t            op_a, op_b, big, sm;
    fp_class_e      cls_a, cls_b;
    logic [E_W+M_W-1:0] key_a, key_b;
    logic           big_z, sm_z;
    logic [MW4-1:0] ext_sm, al;
    logic [E_W-1:0] diff;
    logic [2*MW4-1:0] wide;

    always_comb begin
        op_a  = {sa_i, ea_i, ma_i};
        op_b  = {sb_i, eb_i, mb_i};
        cls_a = fp_classify(ea_i == '0, ea_i == E_ONES, ma_i != '0);
        cls_b = fp_classify(eb_i == '0, eb_i == E_ONES, mb_i != '0);
        key_a = (cls_a == ZERO) ? '0 : {ea_i, ma_i};
        key_b = (cls_b == ZERO) ? '0 : {eb_i, mb_i};
        if (key_a >= key_b) begin
            big   = op_a;
            sm    = op_b;
            big_z = (cls_a == ZERO);
            sm_z  = (cls_b == ZERO);
        end else begin
            big   = op_b;
            sm    = op_a;
            big_z = (cls_b == ZERO);
            sm_z  = (cls_a == ZERO);
        end
        ext_sm = sm_z ? '0 : {1'b1, sm.m, 3'b000};
        diff   = big.e - sm.e;
        wide   = {ext_sm, {MW4{1'b0}}} >> diff;
        // Bits shifted past the guard/round positions collapse into the sticky LSB.
        if (diff >= FAR)
            al = {{(MW4-1){1'b0}}, |ext_sm};
        else
            al = wide[2*MW4-1:MW4] | {{(MW4-1){1'b0}}, |wide[MW4-1:0]};

        s1_d.s_big   = big.s;
        s1_d.sub     = big.s ^ sm.s;
        s1_d.e_big   = big.e;
        s1_d.mag_big = big_z ? '0 : {1'b1, big.m, 3'b000};
        s1_d.mag_sm  = al;
        s1_d.nan     = (cls_a == NAN) | (cls_b == NAN) |
                       ((cls_a == INF) & (cls_b == INF) & (sa_i != sb_i));
        s1_d.inf     = (cls_a == INF) | (cls_b == INF);
        s1_d.inf_s   = (cls_a == INF) ? sa_i : sb_i;
        s1_d.zsign   = sa_i & sb_i;
    end

    // ---------------- Stage 2: magnitude add/subtract ----------------
    always_comb begin
        s2_d.s     = s1_q.s_big;
        s2_d.e     = s1_q.e_big;
        s2_d.sum   = s1_q.sub ? ({1'b0, s1_q.mag_big} - {1'b0, s1_q.mag_sm})
                              : ({1'b0, s1_q.mag_big} + {1'b0, s1_q.mag_sm});
        s2_d.nan   = s1_q.nan;
        s2_d.inf   = s1_q.inf;
        s2_d.inf_s = s1_q.inf_s;
        s2_d.zsign = s1_q.zsign;
    end

    // ---------------- Stage 3: normalise, round, specials ----------------
    logic [LW-1:0]  lz;
    logic [SW-1:0]  norm;
    logic [E_W+1:0] e_norm, e_rnd;
    logic [M_W-1:0] mant;
    logic [M_W:0]   rnd;
    logic           g, r, st, inex, uflow, oflow;
    logic           res_s;
    logic [E_W-1:0] res_e;
    logic [M_W-1:0] res_m;
    logic [2:0]     res_f;

    fp_lzc #(.W(SW)) u_lzc (
        .din(s2_q.sum),
        .cnt(lz)
    );

    always_comb begin
        norm   = s2_q.sum << lz;
        e_norm = {2'b00, s2_q.e} + (E_W+2)'(1) - (E_W+2)'(lz);
        mant   = norm[SW-2:4];
        g      = norm[3];
        r      = norm[2];
        st     = |norm[1:0];
        inex   = g | r | st;
`ifdef FP_ADD_RNE_EN
        rnd    = {1'b0, mant} + (M_W+1)'(g & (r | st | mant[0]));
`else
        rnd    = {1'b0, mant};
`endif
        e_rnd  = e_norm + (E_W+2)'(rnd[M_W]);
        uflow  = e_norm[E_W+1] | (e_norm == '0);
        oflow  = e_rnd >= {2'b00, E_ONES};

        res_s = s2_q.s;
        res_e = e_rnd[E_W-1:0];
        res_m = rnd[M_W-1:0];
        res_f = {2'b00, inex};
        // A clear hidden bit after normalisation means the sum was exactly zero.
        if (s2_q.nan) begin
            res_s = 1'b0;
            res_e = E_ONES;
            res_m = QNAN_M;
            res_f = 3'b010;
        end else if (s2_q.inf) begin
            res_s = s2_q.inf_s;
            res_e = E_ONES;
            res_m = '0;
            res_f = 3'b000;
        end else if (!norm[SW-1]) begin
            res_s = s2_q.zsign;
            res_e = '0;
            res_m = '0;
            res_f = 3'b000;
        end else if (uflow) begin
            res_e = '0;
            res_m = '0;
            res_f = 3'b001;
        end else if (oflow) begin
            res_e = E_ONES;
            res_m = '0;
            res_f = 3'b101;
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            init_done <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            s_o       <= 1'b0;
            e_o       <= '0;
            m_o       <= '0;
            flags_o   <= '0;
        end else begin
            init_done <= 1'b1;
            if (ready_o)
                v1 <= valid_i;
            if (adv2)
                v2 <= v1;
            if (adv3)
                v3 <= v2;
            if (ready_o && valid_i)
                s1_q <= s1_d;
            if (adv2 && v1)
                s2_q <= s2_d;
            if (adv3 && v2) begin
                s_o     <= res_s;
                e_o     <= res_e;
                m_o     <= res_m;
                flags_o <= res_f;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe at bf16 widths; expectations are hand-derived.
module tb_fp_add_pipe;

    logic       clk = 1'b0;
    logic       nreset;
    logic       valid_i, ready_o, ready_i, valid_o;
    logic       sa_i, sb_i, s_o;
    logic [7:0] ea_i, eb_i, e_o;
    logic [6:0] ma_i, mb_i, m_o;
    logic [2:0] flags_o;

    int applied    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_add_pipe #(.E_W(8), .M_W(7)) dut (
        .clk    (clk),
        .nreset (nreset),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .sa_i   (sa_i),
        .ea_i   (ea_i),
        .ma_i   (ma_i),
        .sb_i   (sb_i),
        .eb_i   (eb_i),
        .mb_i   (mb_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .s_o    (s_o),
        .e_o    (e_o),
        .m_o    (m_o),
        .flags_o(flags_o)
    );

    function automatic logic [31:0] pk(input logic s, input logic [7:0] e,
                                       input logic [6:0] m, input logic [2:0] f);
        return {13'b0, s, e, m, f};
    endfunction

    logic [31:0] out_vec;
    assign out_vec = pk(s_o, e_o, m_o, flags_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic as, input logic [7:0] ae, input logic [6:0] am,
                         input logic bs, input logic [7:0] be, input logic [6:0] bm);
        sa_i = as; ea_i = ae; ma_i = am;
        sb_i = bs; eb_i = be; mb_i = bm;
    endtask

    // One operation with an idle sink; latency counted in cycles from the issue cycle.
    task automatic do_op(input string tag,
                         input logic as, input logic [7:0] ae, input logic [6:0] am,
                         input logic bs, input logic [7:0] be, input logic [6:0] bm,
                         input logic [31:0] exp);
        int lat;
        @(negedge clk);
        drive(as, ae, am, bs, be, bm);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        check({tag, " ready_o"}, 32'(ready_o), 32'd1);
        @(posedge clk);
        #1 valid_i = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check(tag, out_vec, exp);
    endtask

    initial begin
        int ip, rp, seen;

        nreset  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 7'h00);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset outputs", out_vec, 32'd0);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset ready_o", 32'(ready_o), 32'd0);
        nreset = 1'b1;
        #1 check("ready_o before first edge", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("ready_o after first edge", 32'(ready_o), 32'd1);

        // Directed single operations
        do_op("1+1",           0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00, pk(0, 8'h80, 7'h00, 3'b000));
        do_op("1+-1",          0, 8'h7F, 7'h00, 1, 8'h7F, 7'h00, pk(0, 8'h00, 7'h00, 3'b000));
        do_op("-0+-0",         1, 8'h00, 7'h00, 1, 8'h00, 7'h00, pk(1, 8'h00, 7'h00, 3'b000));
        do_op("+0+-0",         0, 8'h00, 7'h00, 1, 8'h00, 7'h00, pk(0, 8'h00, 7'h00, 3'b000));
        do_op("max+max",       0, 8'hFE, 7'h7F, 0, 8'hFE, 7'h7F, pk(0, 8'hFF, 7'h00, 3'b101));
        do_op("inf+-inf",      0, 8'hFF, 7'h00, 1, 8'hFF, 7'h00, pk(0, 8'hFF, 7'h40, 3'b010));
        do_op("nan+1",         0, 8'hFF, 7'h01, 0, 8'h7F, 7'h00, pk(0, 8'hFF, 7'h40, 3'b010));
        do_op("-inf+1",        1, 8'hFF, 7'h00, 0, 8'h7F, 7'h00, pk(1, 8'hFF, 7'h00, 3'b000));
`ifdef FP_ADD_RNE_EN
        do_op("1+1.5p-8",      0, 8'h7F, 7'h00, 0, 8'h77, 7'h40, pk(0, 8'h7F, 7'h01, 3'b001));
`else
        do_op("1+1.5p-8",      0, 8'h7F, 7'h00, 0, 8'h77, 7'h40, pk(0, 8'h7F, 7'h00, 3'b001));
`endif
        do_op("1+1p-8 tie",    0, 8'h7F, 7'h00, 0, 8'h77, 7'h00, pk(0, 8'h7F, 7'h00, 3'b001));
        do_op("1.5+0.25",      0, 8'h7F, 7'h40, 0, 8'h7D, 7'h00, pk(0, 8'h7F, 7'h60, 3'b000));
        do_op("2-0.5",         0, 8'h80, 7'h00, 1, 8'h7E, 7'h00, pk(0, 8'h7F, 7'h40, 3'b000));
        do_op("0.5-2 swap",    0, 8'h7E, 7'h00, 1, 8'h80, 7'h00, pk(1, 8'h7F, 7'h40, 3'b000));
        do_op("underflow",     0, 8'h01, 7'h40, 1, 8'h01, 7'h00, pk(0, 8'h00, 7'h00, 3'b001));
        do_op("far sticky",    0, 8'h7F, 7'h00, 0, 8'h6B, 7'h00, pk(0, 8'h7F, 7'h00, 3'b001));
        do_op("subnormal ftz", 0, 8'h7F, 7'h00, 0, 8'h00, 7'h01, pk(0, 8'h7F, 7'h00, 3'b000));

        // Backpressure: six back-to-back ops, sink stalled in cycles 2..7
        @(negedge clk);
        ip = 0;
        rp = 0;
        for (int c = 0; c < 40; c++) begin
            ready_i = !(c >= 2 && c <= 7);
            valid_i = (ip < 6);
            drive(0, 8'h80 + 8'(ip), 7'(ip * 9), 0, 8'h80 + 8'(ip), 7'(ip * 9));
            #1;
            if (valid_o === 1'b1) begin
                check($sformatf("bp result %0d", rp), out_vec,
                      pk(0, 8'h81 + 8'(rp), 7'(rp * 9), 3'b000));
                if (ready_i)
                    rp++;
            end
            if (c == 3) begin
                check("bp ready_o full", 32'(ready_o), 32'd0);
                check("bp accepted when full", 32'(ip), 32'd3);
            end
            if (valid_i && ready_o)
                ip++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        check("bp issued", 32'(ip), 32'd6);
        check("bp returned", 32'(rp), 32'd6);

        // Reset mid-flight discards the pending operation
        ready_i = 1'b1;
        drive(0, 8'h7F, 7'h00, 0, 8'h7F, 7'h00);
        valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("mid reset valid_o", 32'(valid_o), 32'd0);
        check("mid reset outputs", out_vec, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o !== 1'b0)
                seen++;
        end
        check("no output after reset", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-style floating-point adder. Next generation of the combinational bf16_add.
- Exponent and mantissa widths are generic; defaults give bf16.
- Three-stage pipeline: align, add, normalise/round. Valid/ready handshake on both sides.
- Sits between operand-issue logic and the result writeback stage of the FP datapath.

Parameters:
- E_W, 8, exponent width (bias = 2^(E_W-1)-1)
- M_W, 7, stored mantissa width, hidden bit excluded

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- valid_i  in  1  operand pair valid
- ready_o  out  1  block can accept operands this cycle
- sa_i  in  1  sign of A
- ea_i  in  E_W  exponent of A
- ma_i  in  M_W  mantissa of A
- sb_i  in  1  sign of B
- eb_i  in  E_W  exponent of B
- mb_i  in  M_W  mantissa of B
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- s_o  out  1  result sign
- e_o  out  E_W  result exponent
- m_o  out  M_W  result mantissa
- flags_o  out  3  {overflow, invalid, inexact}, qualified by valid_o

Behaviour:
- Reset: clk is the only clock; nreset is asynchronous, active-low.
  - All stage valid bits clear.
  - valid_o=0; s_o, e_o, m_o, flags_o = 0.
  - ready_o=1 one cycle after reset release.
  - Reset asserted mid-operation discards all in-flight operations; no output is produced for them.
- Handshake:
  - Operand transfer occurs on valid_i & ready_o at the clk rising edge.
  - Result transfer occurs on valid_o & ready_i.
  - Outputs hold stable while valid_o & !ready_i.
- Latency and throughput:
  - Result appears on valid_o 3 cycles after acceptance.
  - Throughput is 1 operation per cycle.
- Stall rule:
  - Stage n advances when stage n is empty or stage n+1 advances.
  - ready_o = !v1 | advance1.
  - At most 3 operations are in flight. No loss, no duplication, results in order.
- Stage 1 (align):
  - Classify each operand: zero/subnormal when e=0 (flushed to zero, FTZ); inf when e=all-ones and m=0; NaN when e=all-ones and m!=0.
  - Swap operands so |A|>=|B|.
  - Shift the smaller mantissa right by the exponent difference, keeping guard, round and sticky bits.
  - If the difference is >= M_W+3, the smaller operand contributes only to sticky.
- Stage 2 (add):
  - Add or subtract the (M_W+4)-bit magnitudes according to the sign XOR.
  - Result sign is the sign of the larger operand.
- Stage 3 (normalise/round):
  - Normalise with a leading-zero count.
  - Round per the rounding mode (see Optional Feature).
  - Re-normalise on mantissa carry-out.
- Special cases (checked in priority order):
  - NaN in, or inf + (-inf): canonical NaN (s=0, e=all-ones, m=MSB only); invalid=1.
  - inf + finite: that inf.
  - Exact zero sum: +0, except (-0)+(-0) = -0.
  - Exponent reaching all-ones after rounding: inf with the correct sign; overflow=1, inexact=1.
  - Normalised exponent <= 0 (underflow): flush to signed zero; inexact=1.
- inexact=1 whenever any discarded bit is nonzero.

Optional Feature:
- Macro: FP_ADD_RNE_EN.
- Defined: round-to-nearest-even. Round up when G&(R|S|LSB).
- Undefined: truncation (round toward zero). The round-up adder is removed.
- Both modes:
  - inexact flag behaviour is identical.
  - Overflow produces inf.

Decomposition:
- Package fp_pkg:
  - fp_class_e enum: ZERO, NORM, INF, NAN.
  - Parametrised struct for the {s, e, m} triplet.
  - Bias, all-ones and canonical-NaN constants, as functions of E_W/M_W.
- Sub-module fp_lzc: parametrised leading-zero counter used in stage 3.

Test Plan:
- 1.0+1.0 (s0 e7F m00 twice) -> s0 e80 m00, flags 000, valid_o exactly 3 cycles after acceptance.
- 1.0+(-1.0) -> s0 e00 m00. (-0)+(-0) -> s1 e00 m00. (+0)+(-0) -> s0 e00 m00.
- Max finite (e FE m7F) + same -> s0 eFF m00, flags 101.
- inf+(-inf) -> s0 eFF m40, invalid=1. NaN (eFF m01) + 1.0 -> s0 eFF m40.
- Rounding:
  - 1.0 + 1.5*2^-8 (e77 m40) -> m01 with FP_ADD_RNE_EN; m00 without; inexact=1 in both.
  - 1.0 + 2^-8 (e77 m00) -> m00 (tie to even).
- Backpressure: issue 6 back-to-back ops with ready_i low for cycles 2-7.
  - ready_o drops once 3 ops are in flight.
  - All 6 results return in order, unchanged, each held stable while stalled.
